// File: rtl/int_to_fp_seq.sv
// int_to_fp_seq: multi-cycle 32-bit integer to IEEE-754 single-precision converter.
// Normalises one bit per cycle, then rounds to nearest even (or truncates when ROUND_EN=0).
module int_to_fp_seq #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] op_a,
  input  logic        is_signed,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        inexact
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e      state_q, state_d;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;
  logic [31:0] result_q;
  logic        inexact_q;

  logic        accept;
  logic        op_sign;
  logic [22:0] mant_trunc;
  logic [22:0] mant_rnd;
  logic [23:0] mant_inc;
  logic [7:0]  exp_rnd;
  logic        guard;
  logic        sticky;
  logic        round_up;

  assign accept  = start_valid && start_ready;
  assign op_sign = is_signed & op_a[31];

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = (op_a == 32'd0) ? StDone : StNorm;
      StNorm:  if (mag_q[31]) state_d = StRound;
      StRound: state_d = StDone;
      StDone:  if (result_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and result outputs decoded from the current state.
  always_comb begin
    start_ready  = (state_q == StIdle);
    result_valid = (state_q == StDone);
    result       = result_q;
    inexact      = inexact_q;
  end

  // Round-to-nearest-even on the normalised magnitude; carry out bumps the exponent.
  always_comb begin
    mant_trunc = mag_q[30:8];
    guard      = mag_q[7];
    sticky     = |mag_q[6:0];
    round_up   = ROUND_EN && guard && (sticky || mant_trunc[0]);
    mant_inc   = {1'b0, mant_trunc} + 24'd1;
    mant_rnd   = mant_trunc;
    exp_rnd    = exp_q;
    if (round_up) begin
      mant_rnd = mant_inc[22:0];
      if (mant_inc[23]) exp_rnd = exp_q + 8'd1;
    end
  end

  // Datapath: capture operand, shift left until the leading one hits bit 31, pack result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      exp_q     <= 8'd0;
      result_q  <= 32'd0;
      inexact_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (op_a == 32'd0) begin
              result_q  <= 32'd0;
              inexact_q <= 1'b0;
            end else begin
              sign_q <= op_sign;
              // Negating 0x80000000 wraps to itself, which is the correct magnitude.
              mag_q  <= op_sign ? (~op_a + 32'd1) : op_a;
              exp_q  <= 8'd158;
            end
          end
        end
        StNorm: begin
          if (!mag_q[31]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        StRound: begin
          result_q  <= {sign_q, exp_rnd, mant_rnd};
          inexact_q <= guard | sticky;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Self-checking bench for int_to_fp_seq: rounding and truncating instances run in lockstep
// against an arithmetic reference model.
module tb_int_to_fp_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_valid = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic        is_signed = 1'b0;
  logic        result_ready = 1'b1;

  logic        start_ready, result_valid, inexact;
  logic [31:0] result;
  logic        start_ready_t, result_valid_t, inexact_t;
  logic [31:0] result_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_res, exp_res_t;
  logic        exp_inx;

  always #5 clk = ~clk;

  int_to_fp_seq #(.ROUND_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .is_signed(is_signed), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .inexact(inexact)
  );

  int_to_fp_seq #(.ROUND_EN(1'b0)) dut_t (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready_t),
    .op_a(op_a), .is_signed(is_signed), .result_valid(result_valid_t),
    .result_ready(result_ready), .result(result_t), .inexact(inexact_t)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference conversion: locate the leading one, divide down to 24 significant bits and
  // round on the remainder.
  function automatic void model(input logic [31:0] op, input logic sgn, input bit rnd,
                                output logic [31:0] res, output logic inx, output int lat);
    longint unsigned m, q, rem, half;
    int p, e, sh;
    logic s;
    if (op == 32'd0) begin
      res = 32'd0; inx = 1'b0; lat = 1;
      return;
    end
    s = sgn && op[31];
    m = s ? (64'h1_0000_0000 - {32'd0, op}) : {32'd0, op};
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    lat = (31 - p) + 3;
    e = 127 + p;
    if (p <= 23) begin
      q   = m << (23 - p);
      inx = 1'b0;
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rnd && (rem > half || (rem == half && q[0]))) q = q + 1;
    end
    if (q >= (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    res = {s, e[7:0], q[22:0]};
  endfunction

  // Whenever a result is presented, both instances must match the model.
  always @(negedge clk) begin
    if (reset) begin
      check("valid_lockstep", {31'd0, result_valid_t}, {31'd0, result_valid});
      if (result_valid) begin
        check("result_rne", result, exp_res);
        check("inexact_rne", {31'd0, inexact}, {31'd0, exp_inx});
        check("result_trunc", result_t, exp_res_t);
        check("inexact_trunc", {31'd0, inexact_t}, {31'd0, exp_inx});
        check("busy_not_ready", {31'd0, start_ready}, 32'd0);
      end
    end
  end

  task automatic run_op(input logic [31:0] op, input logic sgn, input int hold);
    int k, lat, lat_t;
    logic inx_t;
    logic [31:0] snap;
    model(op, sgn, 1'b1, exp_res, exp_inx, lat);
    model(op, sgn, 1'b0, exp_res_t, inx_t, lat_t);
    check("ready_before_start", {31'd0, start_ready}, 32'd1);
    start_valid  = 1'b1;
    op_a         = op;
    is_signed    = sgn;
    result_ready = (hold == 0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    op_a        = $urandom;
    is_signed   = $urandom_range(0, 1);
    k = 1;
    while (!result_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, lat);
    if (hold > 0) begin
      snap = result;
      for (int i = 0; i < hold; i++) begin
        start_valid = (i == hold / 2);
        op_a        = 32'h0000_0001;
        @(posedge clk); #1;
        start_valid = 1'b0;
        check("hold_valid", {31'd0, result_valid}, 32'd1);
        check("hold_result", result, snap);
        check("hold_not_ready", {31'd0, start_ready}, 32'd0);
      end
      result_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("valid_drops", {31'd0, result_valid}, 32'd0);
    check("ready_after", {31'd0, start_ready}, 32'd1);
    check("result_kept", result, exp_res);
  endtask

  typedef struct {
    logic [31:0] op;
    logic        sgn;
    logic [31:0] res;
    logic        inx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] r;
    logic        x;
    int          l;

    vecs[0] = '{32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0};
    vecs[3] = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0};
    vecs[4] = '{32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0};
    vecs[5] = '{32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1};
    vecs[6] = '{32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1};
    vecs[7] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};

    // Pin the model to hand-computed values.
    foreach (vecs[i]) begin
      model(vecs[i].op, vecs[i].sgn, 1'b1, r, x, l);
      check("model_result", r, vecs[i].res);
      check("model_inexact", {31'd0, x}, {31'd0, vecs[i].inx});
    end
    model(32'hFFFF_FFFF, 1'b0, 1'b0, r, x, l);
    check("model_trunc", r, 32'h4F7F_FFFF);
    model(32'h0000_0001, 1'b0, 1'b1, r, x, l);
    check("model_latency_max", l, 34);

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, start_ready}, 32'd1);
    check("reset_valid", {31'd0, result_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_inexact", {31'd0, inexact}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].sgn, 0);

    // Backpressure with an ignored start pulse.
    run_op(32'h0000_1234, 1'b0, 10);
    run_op(32'h0000_0000, 1'b0, 10);

    // Reset while normalising discards the operation.
    start_valid = 1'b1;
    op_a        = 32'h0000_0001;
    is_signed   = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("midop_ready", {31'd0, start_ready}, 32'd1);
    check("midop_valid", {31'd0, result_valid}, 32'd0);
    check("midop_result", result, 32'd0);
    reset = 1'b1;
    run_op(32'h0000_0002, 1'b0, 0);
    check("after_reset_op", result, 32'h4000_0000);

    // Randomised operands with a spread of leading-zero counts.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] op;
      op = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) op = ~op;
      if ($urandom_range(0, 19) == 0) op = 32'd0;
      run_op(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 3 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_to_fp_seq.md
Name: int_to_fp_seq

Overview:
- Multi-cycle sequencer that converts a 32-bit integer to an IEEE-754 single-precision float.
- The integer can be treated as signed or unsigned, selected per operation.
- Normalisation is iterative (one bit per cycle) and is followed by round-to-nearest-even.
- Sits beside the ALU on the processor's FP-convert path, with a valid/ready handshake on the request side and on the result side.

Parameters:
- ROUND_EN, default 1. 1 = round to nearest even; 0 = truncate toward zero.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-low.
- start_valid  in  1  request valid.
- start_ready  out  1  block can accept a request.
- op_a  in  32  integer operand.
- is_signed  in  1  1 = op_a is two's complement; 0 = op_a is unsigned.
- result_valid  out  1  result and inexact are valid.
- result_ready  in  1  consumer accepts the result.
- result  out  32  IEEE-754 single-precision result.
- inexact  out  1  result differs from the exact value of the operand.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; start_ready=1; result_valid=0; result=0; inexact=0.
  - Applies from any state. An in-flight operation is discarded with no result.
- States: IDLE, NORM, ROUND, DONE. Internal registers: sign, mag[31:0], exp[7:0], mant[22:0].
- IDLE:
  - start_ready=1.
  - Acceptance occurs when start_valid&&start_ready at an edge; op_a and is_signed are captured then.
  - op_a==0: result<=0x00000000, inexact<=0, go to DONE.
  - Otherwise:
    - sign <= is_signed & op_a[31].
    - mag <= sign ? (~op_a+1) : op_a. 0x80000000 signed gives mag 0x80000000.
    - exp <= 158 (127+31). Go to NORM.
- NORM:
  - If mag[31]==0: mag<=mag<<1, exp<=exp-1, stay in NORM.
  - If mag[31]==1: go to ROUND.
  - With L leading zeros, NORM lasts L+1 cycles (L ≤ 31).
- ROUND:
  - mant=mag[30:8], guard=mag[7], sticky=|mag[6:0].
  - Round up when ROUND_EN && guard && (sticky || mant[0]).
  - Mantissa overflow on round-up (mant==0x7FFFFF): mant=0, exp=exp+1. Max exp is 159, so no infinity case exists.
  - result <= {sign, exp, mant}; inexact <= guard|sticky, regardless of ROUND_EN. Go to DONE.
- DONE:
  - result_valid=1 and start_ready=0.
  - result and inexact are held stable until result_ready==1 at an edge, then go to IDLE.
  - result_ready is ignored in every other state.
- Latency, counted from the acceptance edge to the first cycle with result_valid=1:
  - zero operand: 1 cycle;
  - nonzero operand: L+3 cycles (minimum 3, maximum 34).
- Throughput:
  - The next request is accepted no earlier than the cycle after the result handshake.
  - There is no overlap between operations.
- Outputs:
  - result and inexact keep their last value after the handshake.
  - They are meaningful only while result_valid=1.
- start_valid while busy: ignored, with start_ready=0. The requester must hold the request until it is accepted.

Test Plan:
- Unsigned op_a=0x00000001, result_ready=1 → result=0x3F800000, inexact=0, result_valid 34 cycles after acceptance.
- Unsigned op_a=0xFFFFFFFF → result=0x4F800000, inexact=1, latency 3. With ROUND_EN=0 → result=0x4F7FFFFF, inexact=1.
- Signed cases:
  - 0xFFFFFFFF → 0xBF800000.
  - 0x80000000 → 0xCF000000, inexact=0.
  - Unsigned 0x80000000 → 0x4F000000.
- Tie cases:
  - Unsigned 0x01000001 → 0x4B800000, inexact=1 (tie to even, down).
  - 0x01000003 → 0x4B800002, inexact=1 (tie to even, up).
- Zero and backpressure:
  - op_a=0 → result=0x00000000, result_valid next cycle.
  - Hold result_ready=0 for 10 cycles → result_valid and result stay stable, start_ready stays 0, and a start_valid pulse is not accepted.
- Reset mid-op: op_a=1, assert reset (low) during NORM → next cycle state IDLE, result_valid=0, result=0. A new request op_a=2 → 0x40000000.
